// File: rtl/rv_fetch_ctrl_if.sv
// Instruction-bus read channel plus the decode-side valid/ready handshake of the fetch controller.
// master = fetch controller side, slave = bus/decode side.
interface rv_fetch_ctrl_if;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [29:0] instr_pc;
  logic        instr_ready;

  modport master (
    output bus_req, bus_addr, instr_valid, instr, instr_pc,
    input  bus_gnt, bus_rvalid, bus_rdata, instr_ready
  );

  modport slave (
    input  bus_req, bus_addr, instr_valid, instr, instr_pc,
    output bus_gnt, bus_rvalid, bus_rdata, instr_ready
  );
endinterface

// File: rtl/rv_fetch_ctrl.sv
// Fetch sequencer: issues reads at the current PC, tags them, buffers returned words for decode
// and discards responses that belong to the path abandoned by a redirect.
module rv_fetch_ctrl #(
  parameter int BUF_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_enable,
  input  logic [29:0]     i_pc,
  output logic            o_pc_adv,
  input  logic            i_redirect,
  rv_fetch_ctrl_if.master fe
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW  = $clog2(BUF_DEPTH + 1);
  localparam int BPW = $clog2(BUF_DEPTH);
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t          state_reg;
  logic [CW-1:0]   out_cnt_reg;
  logic [CW-1:0]   out_cnt_next;
  logic [CW-1:0]   kill_cnt_reg;
  logic [CW-1:0]   kill_cnt_next;
  logic [BW-1:0]   buf_count_reg;
  logic [BPW-1:0]  buf_wr_ptr_reg;
  logic [BPW-1:0]  buf_rd_ptr_reg;
  logic [TPW-1:0]  tag_wr_ptr_reg;
  logic [TPW-1:0]  tag_rd_ptr_reg;

  logic [31:0]     buf_data_reg [BUF_DEPTH];
  logic [29:0]     buf_pc_reg   [BUF_DEPTH];
  logic [29:0]     tag_mem_reg  [MAX_OUTSTANDING];

  logic            redirect_act;
  logic            credit_ok;
  logic            bus_req;
  logic            issue;
  logic            rsp;
  logic            keep_rsp;
  logic            buf_pop;
  logic            instr_valid;

  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
  endfunction

  // Credit rule: every in-flight read already owns a buffer slot, so a response is never dropped.
  assign credit_ok    = (int'(out_cnt_reg) < MAX_OUTSTANDING) &&
                        ((int'(out_cnt_reg) + int'(buf_count_reg)) < BUF_DEPTH);
  assign redirect_act = i_redirect && (state_reg != ST_IDLE);
  assign bus_req      = (state_reg == ST_RUN) && i_enable && !i_redirect && credit_ok;
  assign issue        = bus_req && fe.bus_gnt;
  assign rsp          = fe.bus_rvalid && (out_cnt_reg != '0);
  assign keep_rsp     = rsp && !redirect_act && (kill_cnt_reg == '0);
  assign instr_valid  = (buf_count_reg != '0);
  assign buf_pop      = instr_valid && fe.instr_ready && !redirect_act;
  assign out_cnt_next = out_cnt_reg + CW'(issue) - CW'(rsp);

  always_comb begin
    kill_cnt_next = kill_cnt_reg;
    if (redirect_act) begin
      kill_cnt_next = out_cnt_next;
    end else if (rsp && (kill_cnt_reg != '0)) begin
      kill_cnt_next = kill_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg      <= ST_IDLE;
      out_cnt_reg    <= '0;
      kill_cnt_reg   <= '0;
      buf_count_reg  <= '0;
      buf_wr_ptr_reg <= '0;
      buf_rd_ptr_reg <= '0;
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
    end else begin
      out_cnt_reg  <= out_cnt_next;
      kill_cnt_reg <= kill_cnt_next;
      case (state_reg)
        ST_IDLE:  if (i_enable) state_reg <= ST_RUN;
        ST_RUN:   if (i_redirect && (out_cnt_next != '0)) state_reg <= ST_DRAIN;
        ST_DRAIN: if (kill_cnt_next == '0) state_reg <= ST_RUN;
        default:  state_reg <= ST_IDLE;
      endcase
      // Stale tags are dropped here; killed responses then leave the tag pointers untouched.
      if (redirect_act) begin
        buf_count_reg  <= '0;
        buf_wr_ptr_reg <= '0;
        buf_rd_ptr_reg <= '0;
        tag_wr_ptr_reg <= '0;
        tag_rd_ptr_reg <= '0;
      end else begin
        if (issue)    tag_wr_ptr_reg <= tag_inc(tag_wr_ptr_reg);
        if (keep_rsp) tag_rd_ptr_reg <= tag_inc(tag_rd_ptr_reg);
        if (keep_rsp) buf_wr_ptr_reg <= buf_wr_ptr_reg + BPW'(1);
        if (buf_pop)  buf_rd_ptr_reg <= buf_rd_ptr_reg + BPW'(1);
        buf_count_reg <= buf_count_reg + BW'(keep_rsp) - BW'(buf_pop);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_reg[i] <= '0;
        buf_pc_reg[i]   <= '0;
      end
    end else if (keep_rsp) begin
      buf_data_reg[buf_wr_ptr_reg] <= fe.bus_rdata;
      buf_pc_reg[buf_wr_ptr_reg]   <= tag_mem_reg[tag_rd_ptr_reg];
    end
  end

  always_ff @(posedge i_clk) begin
    if (issue) tag_mem_reg[tag_wr_ptr_reg] <= i_pc;
  end

  assign o_pc_adv       = issue;
  assign fe.bus_req     = bus_req;
  assign fe.bus_addr    = i_pc;
  assign fe.instr_valid = instr_valid;
  assign fe.instr       = buf_data_reg[buf_rd_ptr_reg];
  assign fe.instr_pc    = buf_pc_reg[buf_rd_ptr_reg];

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Directed bench for rv_fetch_ctrl: in-order bus model with a one-cycle response, a PC register
// model, and hand-derived cycle expectations for each scenario.
module tb_rv_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic [29:0] redir_tgt = '0;
  logic [29:0] pc = '0;
  logic        pc_adv;
  logic        ready = 1'b0;
  logic        gnt = 1'b0;
  logic        rsp_en = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_fetch_ctrl_if fe_if ();

  assign fe_if.bus_gnt     = gnt;
  assign fe_if.bus_rvalid  = rvalid;
  assign fe_if.bus_rdata   = rdata;
  assign fe_if.instr_ready = ready;

  rv_fetch_ctrl dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_enable   (enable),
    .i_pc       (pc),
    .o_pc_adv   (pc_adv),
    .i_redirect (redirect),
    .fe         (fe_if)
  );

  function automatic logic [31:0] mk(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Bus and PC models sample the DUT on the falling edge and update after the rising edge.
  logic        iss_s = 1'b0, adv_s = 1'b0, redir_s = 1'b0;
  logic [29:0] iss_addr_s = '0, tgt_s = '0;
  logic [29:0] pend[$];

  always @(negedge clk) begin
    iss_s      = fe_if.bus_req && fe_if.bus_gnt;
    iss_addr_s = fe_if.bus_addr;
    adv_s      = pc_adv;
    redir_s    = redirect;
    tgt_s      = redir_tgt;
  end

  always @(posedge clk) begin
    if (iss_s) pend.push_back(iss_addr_s);
    #2;
    if (!rst_n) begin
      pend.delete();
      rvalid = 1'b0;
      rdata  = '0;
    end else if (rsp_en && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = mk(pend.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    #3;
    if (!rst_n)       pc = '0;
    else if (redir_s) pc = tgt_s;
    else if (adv_s)   pc = pc + 30'd1;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Leaves the caller in cycle c0 (state still IDLE) with the knobs applied.
  task automatic start(input logic rdy, input logic g, input logic r);
    next_cyc();
    rst_n = 1'b0; enable = 1'b0; redirect = 1'b0; ready = 1'b0;
    gnt = 1'b0; rsp_en = 1'b0; redir_tgt = '0;
    smp();
    chk("rst_req", fe_if.bus_req, 0);
    chk("rst_valid", fe_if.instr_valid, 0);
    chk("rst_instr", fe_if.instr, 0);
    chk("rst_instr_pc", fe_if.instr_pc, 0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1; enable = 1'b1; ready = rdy; gnt = g; rsp_en = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [29:0] exp_pc;
    int          adv_tot;

    // Zero-wait bus, decode always ready.
    start(1'b1, 1'b1, 1'b1);
    smp(); chk("t2_c0_req_idle", fe_if.bus_req, 0);
    next_cyc();
    exp_pc = '0;
    adv_tot = 0;
    for (int i = 1; i < 28; i++) begin
      smp();
      if (i == 1) begin
        chk("t2_c1_req", fe_if.bus_req, 1);
        chk("t2_c1_addr", fe_if.bus_addr, 30'h0);
        chk("t2_c1_adv", pc_adv, 1);
      end
      if (i == 2) begin
        chk("t2_c2_addr", fe_if.bus_addr, 30'h1);
        chk("t2_c2_valid_latency", fe_if.instr_valid, 0);
      end
      if (i == 3) chk("t2_c3_credit_req", fe_if.bus_req, 0);
      if (pc_adv) adv_tot++;
      if (fe_if.instr_valid) begin
        chk("t2_pc", fe_if.instr_pc, exp_pc);
        chk("t2_instr", fe_if.instr, mk(exp_pc));
        exp_pc = exp_pc + 30'd1;
      end
      next_cyc();
    end
    chk("t2_progress", exp_pc >= 30'd12, 1);
    chk("t2_inflight_bound", (adv_tot - int'(exp_pc)) <= 2, 1);

    // Reset asserted mid-stream with reads in flight.
    rst_n = 1'b0;
    smp();
    chk("t1_req", fe_if.bus_req, 0);
    chk("t1_adv", pc_adv, 0);
    chk("t1_valid", fe_if.instr_valid, 0);
    chk("t1_instr", fe_if.instr, 0);
    chk("t1_instr_pc", fe_if.instr_pc, 0);
    next_cyc();
    rst_n = 1'b1; enable = 1'b0;
    smp(); chk("t1_noen_req_a", fe_if.bus_req, 0);
    chk("t1_noen_valid", fe_if.instr_valid, 0);
    next_cyc();
    smp(); chk("t1_noen_req_b", fe_if.bus_req, 0);
    next_cyc();
    enable = 1'b1;
    smp(); chk("t1_idle_req", fe_if.bus_req, 0);
    next_cyc();
    smp();
    chk("t1_run_req", fe_if.bus_req, 1);
    chk("t1_run_addr", fe_if.bus_addr, 30'h0);
    chk("t1_run_no_stale", fe_if.instr_valid, 0);

    // Decode stall: credit limits issues to the buffer depth.
    start(1'b0, 1'b1, 1'b1);
    adv_tot = 0;
    for (int i = 0; i < 12; i++) begin
      smp();
      if (pc_adv) adv_tot++;
      if (i == 11) begin
        chk("t3_req_stalled", fe_if.bus_req, 0);
        chk("t3_valid", fe_if.instr_valid, 1);
        chk("t3_head_pc", fe_if.instr_pc, 30'h0);
        chk("t3_head_instr", fe_if.instr, mk(30'h0));
      end
      next_cyc();
    end
    chk("t3_issue_count", adv_tot, 2);
    ready = 1'b1;
    exp_pc = '0;
    for (int i = 0; i < 15; i++) begin
      smp();
      if (fe_if.instr_valid) begin
        chk("t3_pc", fe_if.instr_pc, exp_pc);
        chk("t3_instr", fe_if.instr, mk(exp_pc));
        exp_pc = exp_pc + 30'd1;
      end
      next_cyc();
    end
    chk("t3_resume_progress", exp_pc >= 30'd6, 1);

    // Redirect with two outstanding and a response in the same cycle.
    start(1'b1, 1'b1, 1'b0);
    smp(); next_cyc();
    smp(); chk("t4_c1_addr", fe_if.bus_addr, 30'h0); chk("t4_c1_adv", pc_adv, 1);
    next_cyc();
    smp(); chk("t4_c2_addr", fe_if.bus_addr, 30'h1); chk("t4_c2_adv", pc_adv, 1);
    next_cyc();
    redirect = 1'b1; redir_tgt = 30'h100; rsp_en = 1'b1;
    smp(); chk("t4_redir_req", fe_if.bus_req, 0); chk("t4_redir_adv", pc_adv, 0);
    next_cyc();
    redirect = 1'b0;
    smp(); chk("t4_after_valid", fe_if.instr_valid, 0); chk("t4_drain_req", fe_if.bus_req, 0);
    next_cyc();
    smp();
    chk("t4_c5_req", fe_if.bus_req, 1);
    chk("t4_c5_addr", fe_if.bus_addr, 30'h100);
    chk("t4_c5_dropped", fe_if.instr_valid, 0);
    next_cyc();
    smp(); chk("t4_c6_addr", fe_if.bus_addr, 30'h101); chk("t4_c6_valid", fe_if.instr_valid, 0);
    next_cyc();
    smp();
    chk("t4_c7_valid", fe_if.instr_valid, 1);
    chk("t4_c7_pc", fe_if.instr_pc, 30'h100);
    chk("t4_c7_instr", fe_if.instr, mk(30'h100));
    next_cyc();
    smp(); chk("t4_c8_pc", fe_if.instr_pc, 30'h101); chk("t4_c8_instr", fe_if.instr, mk(30'h101));

    // Grant withheld: request and address hold, PC does not advance.
    start(1'b1, 1'b0, 1'b1);
    smp(); next_cyc();
    redirect = 1'b1; redir_tgt = 30'h40;
    smp(); chk("t5_redir_req", fe_if.bus_req, 0);
    next_cyc();
    redirect = 1'b0;
    for (int i = 2; i < 7; i++) begin
      smp();
      chk("t5_hold_req", fe_if.bus_req, 1);
      chk("t5_hold_addr", fe_if.bus_addr, 30'h40);
      chk("t5_hold_adv", pc_adv, 0);
      next_cyc();
    end
    gnt = 1'b1;
    smp(); chk("t5_gnt_adv", pc_adv, 1); chk("t5_gnt_addr", fe_if.bus_addr, 30'h40);
    next_cyc();
    smp(); chk("t5_next_addr", fe_if.bus_addr, 30'h41);
    next_cyc();
    smp(); chk("t5_valid_pc", fe_if.instr_pc, 30'h40); chk("t5_valid", fe_if.instr_valid, 1);

    // Back-to-back redirects while draining.
    start(1'b1, 1'b1, 1'b0);
    smp(); next_cyc();
    smp(); next_cyc();
    smp(); next_cyc();
    redirect = 1'b1; redir_tgt = 30'h200;
    smp(); chk("t6_r1_req", fe_if.bus_req, 0);
    next_cyc();
    redir_tgt = 30'h300;
    smp(); chk("t6_r2_req", fe_if.bus_req, 0); chk("t6_r2_valid", fe_if.instr_valid, 0);
    next_cyc();
    redirect = 1'b0; rsp_en = 1'b1;
    smp(); chk("t6_drain_req_a", fe_if.bus_req, 0); chk("t6_drain_valid_a", fe_if.instr_valid, 0);
    next_cyc();
    smp(); chk("t6_drain_req_b", fe_if.bus_req, 0); chk("t6_drain_valid_b", fe_if.instr_valid, 0);
    next_cyc();
    exp_pc = 30'h300;
    for (int i = 0; i < 15; i++) begin
      smp();
      if (i == 0) begin
        chk("t6_run_req", fe_if.bus_req, 1);
        chk("t6_run_addr", fe_if.bus_addr, 30'h300);
      end
      if (fe_if.instr_valid) begin
        chk("t6_pc", fe_if.instr_pc, exp_pc);
        chk("t6_instr", fe_if.instr, mk(exp_pc));
        exp_pc = exp_pc + 30'd1;
      end
      next_cyc();
    end
    chk("t6_progress", exp_pc >= 30'h304, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
